// File: rtl/bcd_disp_scan.sv
// bcd_disp_scan: converts an 8-bit binary value to three BCD digits with a
// serial double-dabble engine (8 cycles per conversion), then time-multiplexes
// the digits onto a shared 4-bit nibble with active-low digit enables.
//
// Optional feature: define BCD_DISP_BLANK_LZ_EN to blank leading zeros
// (hundreds and tens slots disabled when they would show a leading 0).
module bcd_disp_scan #(
  parameter int SCAN_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] value,
  output logic       busy,
  output logic [3:0] digit,
  output logic [2:0] dig_sel_n
);

  localparam int             PW      = $clog2(SCAN_DIV);
  localparam logic [PW-1:0]  PRE_MAX = PW'(SCAN_DIV - 1);

  typedef enum logic {
    IDLE,
    CONV
  } state_t;

  state_t        state;
  logic [3:0]    cnt;
  logic [7:0]    shift_q;
  logic [11:0]   scratch_q;
  logic [3:0]    ones_q;
  logic [3:0]    tens_q;
  logic [3:0]    hund_q;

  logic [PW-1:0] pre_q;
  logic [1:0]    idx_q;

  logic [11:0]   adj;
  logic [11:0]   conv_scratch;
  logic [7:0]    conv_shift;
  logic          done;

  logic          wrap;
  logic [1:0]    idx_nxt;
  logic [3:0]    ones_nxt;
  logic [3:0]    tens_nxt;
  logic [3:0]    hund_nxt;
  logic [3:0]    digit_nxt;
  logic [2:0]    sel_nxt;

  // Double-dabble step: add 3 to any nibble >= 5, then shift one bit in.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    adj = scratch_q;
    for (int i = 0; i < 3; i++) begin
      if (scratch_q[i*4 +: 4] >= 4'd5) adj[i*4 +: 4] = scratch_q[i*4 +: 4] + 4'd3;
    end
    conv_scratch = {adj[10:0], shift_q[7]};
    conv_shift   = {shift_q[6:0], 1'b0};
    done         = (state == CONV) && (cnt == 4'd1);
  end

  // Conversion FSM; display registers update atomically on the last step.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      cnt       <= 4'd0;
      shift_q   <= 8'd0;
      scratch_q <= 12'd0;
      ones_q    <= 4'd0;
      tens_q    <= 4'd0;
      hund_q    <= 4'd0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      case (state)
        IDLE: begin
          if (load) begin
            shift_q   <= value;
            scratch_q <= 12'd0;
            cnt       <= 4'd8;
            busy      <= 1'b1;
            state     <= CONV;
          end
        end
        CONV: begin
          scratch_q <= conv_scratch;
          shift_q   <= conv_shift;
          cnt       <= cnt - 4'd1;
          if (done) begin
            state  <= IDLE;
            busy   <= 1'b0;
            ones_q <= conv_scratch[3:0];
            tens_q <= conv_scratch[7:4];
            hund_q <= conv_scratch[11:8];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Next scan index and next display contents, so a wrap and an update in
  // the same edge are both reflected in the registered outputs.
  always_comb begin
    wrap     = (pre_q == PRE_MAX);
    idx_nxt  = idx_q;
    if (wrap) idx_nxt = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
    ones_nxt = done ? conv_scratch[3:0]  : ones_q;
    tens_nxt = done ? conv_scratch[7:4]  : tens_q;
    hund_nxt = done ? conv_scratch[11:8] : hund_q;
    case (idx_nxt)
      2'd1:    digit_nxt = tens_nxt;
      2'd2:    digit_nxt = hund_nxt;
      default: digit_nxt = ones_nxt;
    endcase
    sel_nxt = ~(3'b001 << idx_nxt);
`ifdef BCD_DISP_BLANK_LZ_EN
    if (idx_nxt == 2'd2 && hund_nxt == 4'd0) sel_nxt = 3'b111;
    if (idx_nxt == 2'd1 && hund_nxt == 4'd0 && tens_nxt == 4'd0) sel_nxt = 3'b111;
`endif
  end

  // Free-running scanner with registered digit/enable outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre_q     <= '0;
      idx_q     <= 2'd0;
      digit     <= 4'h0;
      dig_sel_n <= 3'b110;
    end else begin
      pre_q     <= wrap ? '0 : pre_q + 1'b1;
      idx_q     <= idx_nxt;
      digit     <= digit_nxt;
      dig_sel_n <= sel_nxt;
    end
  end

endmodule
